// File: rtl/hs_sync_pkg.sv
// Shared constants for the hs_sync req/ack toggle handshake crossing.
package hs_sync_pkg;

    // Default depth of every synchroniser chain in the crossing.
    localparam int HS_SYNC_N_DEFAULT = 2;

    // Name of the attribute placed on synchroniser flops so that
    // placement keeps them adjacent and timing treats them as CDC.
    localparam string HS_CDC_ATTR = "ASYNC_REG";

endpackage

// File: rtl/hs_sync_chain.sv
// Single-bit N-flop synchroniser with asynchronous active-low reset.
// The ena input lets the receiving domain freeze the chain together
// with the rest of its state.
module hs_sync_chain
    import hs_sync_pkg::*;
#(
    parameter int SYNC_N = HS_SYNC_N_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_N-1:0] sync_q;
    logic [SYNC_N-1:0] sync_d;

    // Shift the asynchronous bit one stage deeper when enabled.
    always_comb begin
        sync_d = sync_q;
        if (ena) begin
            sync_d = {sync_q[SYNC_N-2:0], d};
        end
    end

    // Chain registers; reset clears every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_N-1];

endmodule

// File: rtl/hs_sync.sv
// Multi-bit clkA -> clkB crossing using a two-phase req/ack toggle
// handshake. One word in flight at a time; the held word is only read
// by clkB after the request toggle has passed through a synchroniser,
// so the data bus itself needs no per-bit synchronisation.
module hs_sync
    import hs_sync_pkg::*;
#(
    parameter int W      = 8,
    parameter int SYNC_N = HS_SYNC_N_DEFAULT,
    parameter int DST_BP = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clkA,
    input  logic             clkB,
    input  logic             rst_n,
    input  logic             enaA,
    input  logic             enaB,
    input  logic             src_valid,
    input  logic [W-1:0]     src_data,
    output logic             src_ready,
    output logic             dst_valid,
    output logic [W-1:0]     dst_data,
    input  logic             dst_ready,
    output logic [CNT_W-1:0] dst_count
);

    // ---------------- clkA side ----------------
    logic         req_tog_q, req_tog_d;
    logic [W-1:0] hold_q, hold_d;
    logic         ack_s;
    logic         idle;
    logic         accept;

    // Source is idle once the ack toggle has caught up with the request.
    assign idle      = (ack_s == req_tog_q);
    assign src_ready = idle & enaA;
    assign accept    = src_valid & src_ready;

    // Capture the word and flip the request toggle on accept.
    always_comb begin
        req_tog_d = req_tog_q;
        hold_d    = hold_q;
        if (accept) begin
            req_tog_d = ~req_tog_q;
            hold_d    = src_data;
        end
    end

    // Source-domain registers.
    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            req_tog_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            req_tog_q <= req_tog_d;
            hold_q    <= hold_d;
        end
    end

    // ---------------- clkB side ----------------
    logic             req_s;
    logic             dst_tog_q, dst_tog_d;
    logic             dst_valid_q, dst_valid_d;
    logic [W-1:0]     dst_data_q, dst_data_d;
    logic [CNT_W-1:0] dst_count_q, dst_count_d;
    logic             bp_off;
    logic             new_word;
    logic             consume;

    assign bp_off   = (DST_BP == 0);
    assign new_word = (req_s != dst_tog_q) & ~dst_valid_q;
    assign consume  = dst_valid_q & (bp_off | dst_ready);

    // Deliver a new word, then return the ack toggle once it is consumed.
    // new_word and consume are exclusive since new_word needs ~dst_valid.
    always_comb begin
        dst_tog_d   = dst_tog_q;
        dst_valid_d = dst_valid_q;
        dst_data_d  = dst_data_q;
        dst_count_d = dst_count_q;
        if (enaB) begin
            if (new_word) begin
                dst_valid_d = 1'b1;
                dst_data_d  = hold_q;
                dst_count_d = dst_count_q + 1'b1;
            end
            if (consume) begin
                dst_valid_d = 1'b0;
                dst_tog_d   = req_s;
            end
        end
    end

    // Destination-domain registers.
    always_ff @(posedge clkB or negedge rst_n) begin
        if (!rst_n) begin
            dst_tog_q   <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            dst_count_q <= '0;
        end else begin
            dst_tog_q   <= dst_tog_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
            dst_count_q <= dst_count_d;
        end
    end

    assign dst_valid = dst_valid_q;
    assign dst_data  = dst_data_q;
    assign dst_count = dst_count_q;

    // Request toggle into clkB; frozen along with the rest of clkB state.
    hs_sync_chain #(.SYNC_N(SYNC_N)) u_req_sync (
        .clk   (clkB),
        .rst_n (rst_n),
        .ena   (enaB),
        .d     (req_tog_q),
        .q     (req_s)
    );

    // Ack toggle back into clkA; enaA only gates new accepts.
    hs_sync_chain #(.SYNC_N(SYNC_N)) u_ack_sync (
        .clk   (clkA),
        .rst_n (rst_n),
        .ena   (1'b1),
        .d     (dst_tog_q),
        .q     (ack_s)
    );

endmodule

// File: tb/tb_hs_sync.sv
// Bench for hs_sync: three instances share the source stimulus
// (u0: DST_BP=0, u1: DST_BP=1, u2: DST_BP=0 with CNT_W=2). Expected
// records are queued at accept time and checked at delivery.
`timescale 1ns/1ps
module tb_hs_sync;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } vec_t;

    logic       clkA = 1'b0;
    logic       clkB = 1'b0;
    int         hb = 7;
    logic       rst_n, enaA, enaB, src_valid, dst_ready;
    logic [7:0] src_data;
    logic [2:0] src_ready, dst_valid;
    logic [7:0] dst_data [3];
    logic [7:0] dst_cnt8 [2];
    logic [1:0] dst_cnt2;

    int   tests = 0;
    int   fails = 0;
    int   n_sent = 0;
    int   deliv [3] = '{0, 0, 0};
    logic [2:0] prev_v = '0;
    vec_t sb0[$], sb1[$], sb2[$];
    vec_t tbl [5];

    always #6 clkA = ~clkA;
    always #(hb) clkB = ~clkB;

    hs_sync #(.W(8), .SYNC_N(2), .DST_BP(0), .CNT_W(8)) u0 (
        .clkA(clkA), .clkB(clkB), .rst_n(rst_n), .enaA(enaA), .enaB(enaB),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready[0]),
        .dst_valid(dst_valid[0]), .dst_data(dst_data[0]), .dst_ready(dst_ready),
        .dst_count(dst_cnt8[0]));
    hs_sync #(.W(8), .SYNC_N(2), .DST_BP(1), .CNT_W(8)) u1 (
        .clkA(clkA), .clkB(clkB), .rst_n(rst_n), .enaA(enaA), .enaB(enaB),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready[1]),
        .dst_valid(dst_valid[1]), .dst_data(dst_data[1]), .dst_ready(dst_ready),
        .dst_count(dst_cnt8[1]));
    hs_sync #(.W(8), .SYNC_N(2), .DST_BP(0), .CNT_W(2)) u2 (
        .clkA(clkA), .clkB(clkB), .rst_n(rst_n), .enaA(enaA), .enaB(enaB),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready[2]),
        .dst_valid(dst_valid[2]), .dst_data(dst_data[2]), .dst_ready(dst_ready),
        .dst_count(dst_cnt2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Compare one delivered word of instance k against the scoreboard.
    task automatic check_out(input int k);
        vec_t e;
        logic have;
        logic [7:0] got_c, exp_c;
        have = 1'b0;
        e    = '0;
        case (k)
            0: if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
            1: if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
            default: if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1'b1; end
        endcase
        deliv[k]++;
        if (!have) begin
            tests++;
            fails++;
            $display("FAIL spurious%0d: got dst_valid=1 data %0h, expected no word", k, dst_data[k]);
        end else begin
            got_c = (k == 2) ? {6'd0, dst_cnt2} : dst_cnt8[k];
            exp_c = (k == 2) ? {6'd0, e.cnt2} : e.cnt8;
            chk($sformatf("data%0d", k), {24'd0, dst_data[k]}, {24'd0, e.data});
            chk($sformatf("count%0d", k), {24'd0, got_c}, {24'd0, exp_c});
            $display("[TB] u%0d delivered %0h count %0h", k, dst_data[k], got_c);
        end
        if (k != 1) begin
            chk($sformatf("pulse%0d", k), {31'd0, prev_v[k]}, 32'd0);
        end
    endtask

    // Delivery monitor, sampled on the inactive clkB edge.
    always @(negedge clkB) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_n && dst_valid[k] && (k != 1 || dst_ready)) begin
                check_out(k);
            end
            prev_v[k] = rst_n & dst_valid[k];
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clkA);
        while (src_ready !== 3'b111 && n < 400) begin
            @(negedge clkA);
            n++;
        end
        if (n >= 400) fail_now(name);
    endtask

    task automatic wait_deliv(input int target, input string name);
        int n;
        n = 0;
        while (!(deliv[0] >= target && deliv[1] >= target && deliv[2] >= target) && n < 400) begin
            @(negedge clkB);
            n++;
        end
        if (n >= 400) fail_now(name);
    endtask

    // Offer one word; keep=1 leaves src_valid high with junk data
    // afterwards, which the DUT must ignore until ready returns.
    task automatic send(input logic [7:0] d, input logic [7:0] c8, input logic [1:0] c2,
                        input logic keep);
        vec_t e;
        wait_ready("ready_wait");
        src_valid = 1'b1;
        src_data  = d;
        @(posedge clkA);
        e = '{data: d, cnt8: c8, cnt2: c2};
        sb0.push_back(e);
        sb1.push_back(e);
        sb2.push_back(e);
        n_sent++;
        @(negedge clkA);
        if (keep) src_data = ~d;
        else      src_valid = 1'b0;
        chk("ready_drop", {29'd0, src_ready}, 32'd0);
    endtask

    task automatic send_auto(input logic [7:0] d, input logic keep);
        logic [7:0] c;
        c = 8'(n_sent + 1);
        send(d, c, c[1:0], keep);
    endtask

    task automatic pulse_reset();
        @(negedge clkA);
        rst_n = 1'b0;
        sb0.delete();
        sb1.delete();
        sb2.delete();
        n_sent = 0;
        repeat (3) @(negedge clkA);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), {31'd0, dst_valid[k]}, 32'd0);
            chk($sformatf("rst_data%0d", k), {24'd0, dst_data[k]}, 32'd0);
            chk($sformatf("rst_ready%0d", k), {31'd0, src_ready[k]}, 32'd1);
        end
        chk("rst_count0", {24'd0, dst_cnt8[0]}, 32'd0);
        chk("rst_count2", {30'd0, dst_cnt2}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        tbl[0] = '{data: 8'hA5, cnt8: 8'd1, cnt2: 2'd1};
        tbl[1] = '{data: 8'h5A, cnt8: 8'd2, cnt2: 2'd2};
        tbl[2] = '{data: 8'hC3, cnt8: 8'd3, cnt2: 2'd3};
        tbl[3] = '{data: 8'h3C, cnt8: 8'd4, cnt2: 2'd0};
        tbl[4] = '{data: 8'hFF, cnt8: 8'd5, cnt2: 2'd1};

        rst_n = 1'b0; enaA = 1'b1; enaB = 1'b1;
        src_valid = 1'b0; src_data = 8'h00; dst_ready = 1'b1;
        pulse_reset();

        // Single words with table-given counts (count wraps on u2).
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].data, tbl[i].cnt8, tbl[i].cnt2, 1'b0);
            wait_ready("tbl_done");
        end
        chk("tbl_deliv", deliv[0], 32'd5);

        // Back-to-back bursts: clkB 3x slower, then 3x faster.
        pulse_reset();
        base = deliv[0];
        hb = 18;
        for (int i = 1; i <= 16; i++) send_auto(8'(i), 1'b1);
        src_valid = 1'b0;
        wait_ready("slow_done");
        chk("slow_deliv", deliv[0] - base, 32'd16);
        chk("slow_count", {24'd0, dst_cnt8[0]}, 32'd16);
        hb = 2;
        for (int i = 1; i <= 16; i++) send_auto(8'(i), 1'b1);
        src_valid = 1'b0;
        wait_ready("fast_done");
        chk("fast_deliv", deliv[2] - base, 32'd32);
        hb = 7;

        // Destination back-pressure on u1.
        @(posedge clkB); #1 dst_ready = 1'b0;
        send_auto(8'h3C, 1'b0);
        begin
            int n;
            n = 0;
            while (dst_valid[1] !== 1'b1 && n < 200) begin
                @(negedge clkB);
                n++;
            end
            if (n >= 200) fail_now("bp_arrive");
        end
        repeat (20) begin
            @(negedge clkB);
            chk("bp_valid", {31'd0, dst_valid[1]}, 32'd1);
            chk("bp_data", {24'd0, dst_data[1]}, 32'h3C);
            chk("bp_src_ready", {31'd0, src_ready[1]}, 32'd0);
        end
        @(posedge clkB); #1 dst_ready = 1'b1;
        @(negedge clkB);
        @(negedge clkB);
        chk("bp_release", {31'd0, dst_valid[1]}, 32'd0);
        wait_ready("bp_done");

        // Reset while a word is in flight: word dropped, nothing afterwards.
        send_auto(8'h77, 1'b0);
        rst_n = 1'b0;
        base = deliv[0];
        pulse_reset();
        repeat (30) @(negedge clkB);
        chk("rst_drop", deliv[0] + deliv[1] + deliv[2] - 3 * base, 32'd0);

        // enaB stall: no delivery until enabled.
        @(posedge clkB); #1 enaB = 1'b0;
        send_auto(8'h99, 1'b0);
        repeat (30) @(negedge clkB);
        chk("enab_stall", deliv[0] - base, 32'd0);
        chk("enab_valid", {29'd0, dst_valid}, 32'd0);
        @(posedge clkB); #1 enaB = 1'b1;
        wait_deliv(base + 1, "enab_deliv");
        wait_ready("enab_done");

        // enaA blocks accepts but not an in-flight word.
        enaA = 1'b0;
        @(negedge clkA);
        chk("enaa_ready", {29'd0, src_ready}, 32'd0);
        enaA = 1'b1;
        send_auto(8'h42, 1'b0);
        enaA = 1'b0;
        wait_deliv(base + 2, "enaa_deliv");
        repeat (10) @(negedge clkA);
        chk("enaa_hold", {29'd0, src_ready}, 32'd0);
        enaA = 1'b1;
        @(negedge clkA);
        chk("enaa_back", {29'd0, src_ready}, 32'd7);

        repeat (10) @(negedge clkB);
        chk("sb_empty", sb0.size() + sb1.size() + sb2.size(), 32'd0);
        chk("deliv_equal", deliv[1], deliv[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
